// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
//   Shares one AXI read master port (AR + R, 64-bit data) among NREQ
//   requesters. One burst is granted at a time by round-robin. The grant is
//   held until the beat carrying rlast is accepted. R beats are routed only
//   to the granted requester.
//
// Optional feature (compile-time macro AXI_RD_ARB_LENCHK_EN):
//   when defined, a beat counter checks rlast against the issued arlen and
//   raises the sticky len_err flag. When undefined, len_err is tied to 0.
//
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   req_ar*           : per-requester AR fields/valid (slice i = [i*W +: W])
//   req_arready       : one-hot (or zero) address accept, combinational
//   req_rdata         : read data broadcast to every requester
//   req_rvalid/rlast  : routed to the granted requester only
//   req_rready        : per-requester data ready (only the owner's bit is used)
//   m_axi_ar*         : registered AR channel toward the read bridge
//   m_axi_r*          : R channel from the read bridge (pass-through)
//   grant             : index of the current owner, valid outside IDLE
//   busy              : FSM is not in IDLE
//   len_err           : sticky beat-count error (see macro above)
module axi_read_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ*AW-1:0]      req_araddr,
  input  logic [NREQ*8-1:0]       req_arlen,
  input  logic [NREQ*3-1:0]       req_arsize,
  input  logic [NREQ*2-1:0]       req_arburst,
  input  logic [NREQ-1:0]         req_arvalid,
  output logic [NREQ-1:0]         req_arready,
  output logic [63:0]             req_rdata,
  output logic [NREQ-1:0]         req_rlast,
  output logic [NREQ-1:0]         req_rvalid,
  input  logic [NREQ-1:0]         req_rready,
  output logic [AW-1:0]           m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [63:0]             m_axi_rdata,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [$clog2(NREQ)-1:0] grant,
  output logic                    busy,
  output logic                    len_err
);

  localparam int GW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic [7:0]      arlen_q, arlen_d;
  logic [2:0]      arsize_q, arsize_d;
  logic [1:0]      arburst_q, arburst_d;

  logic [GW-1:0]   win_idx;
  logic            win_found;
  logic [NREQ-1:0] grant_oh;
  logic            ar_hs;
  logic            r_hs;

  // Round-robin pick: scan from ptr upward, wrapping modulo NREQ.
  always_comb begin
    int cand;
    cand      = 0;
    win_idx   = ptr_q;
    win_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && req_arvalid[cand]) begin
        win_found = 1'b1;
        win_idx   = GW'(cand);
      end
    end
  end

  assign grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
  assign ar_hs    = (state_q == S_ADDR) && m_axi_arready;
  assign r_hs     = (state_q == S_DATA) && m_axi_rvalid && m_axi_rready;

  // State and latched-request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
    end
  end

  // Next-state logic; the AR fields are captured only when leaving IDLE so
  // a requester that drops arvalid afterwards is still served from the copy.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d   = win_idx;
          araddr_d  = req_araddr[win_idx*AW +: AW];
          arlen_d   = req_arlen[win_idx*8 +: 8];
          arsize_d  = req_arsize[win_idx*3 +: 3];
          arburst_d = req_arburst[win_idx*2 +: 2];
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (ar_hs) state_d = S_DATA;
      end
      S_DATA: begin
        // Termination follows rlast only; the just-served requester moves
        // to lowest priority.
        if (r_hs && m_axi_rlast) begin
          state_d = S_IDLE;
          if (grant_q == GW'(NREQ - 1)) ptr_d = '0;
          else                          ptr_d = grant_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    req_arready   = '0;
    req_rvalid    = '0;
    req_rlast     = '0;
    busy          = (state_q != S_IDLE);
    unique case (state_q)
      S_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) req_arready = grant_oh;
      end
      S_DATA: begin
        m_axi_rready = req_rready[grant_q];
        if (m_axi_rvalid) req_rvalid = grant_oh;
        if (m_axi_rlast)  req_rlast  = grant_oh;
      end
      default: ;
    endcase
  end

  assign req_rdata     = m_axi_rdata;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = arsize_q;
  assign m_axi_arburst = arburst_q;
  assign grant         = grant_q;

`ifdef AXI_RD_ARB_LENCHK_EN
  logic [7:0] cnt_q, cnt_d;
  logic       len_err_q, len_err_d;

  // Counter holds the number of beats still expected after the current one;
  // rlast must coincide with zero. It saturates at zero on overrun.
  always_comb begin
    cnt_d     = cnt_q;
    len_err_d = len_err_q;
    if (ar_hs) begin
      cnt_d = arlen_q;
    end else if (r_hs) begin
      if (m_axi_rlast && (cnt_q != 8'd0))  len_err_d = 1'b1;
      if (!m_axi_rlast && (cnt_q == 8'd0)) len_err_d = 1'b1;
      if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_read_arbiter.sv
module tb_axi_read_arbiter;

  logic         clk;
  logic         rst;
  logic [127:0] req_araddr;
  logic [31:0]  req_arlen;
  logic [11:0]  req_arsize;
  logic [7:0]   req_arburst;
  logic [3:0]   req_arvalid;
  logic [3:0]   req_arready;
  logic [63:0]  req_rdata;
  logic [3:0]   req_rlast;
  logic [3:0]   req_rvalid;
  logic [3:0]   req_rready;
  logic [31:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst;
  logic         m_axi_arvalid;
  logic         m_axi_arready;
  logic [63:0]  m_axi_rdata;
  logic         m_axi_rlast;
  logic         m_axi_rvalid;
  logic         m_axi_rready;
  logic [1:0]   grant;
  logic         busy;
  logic         len_err;

  int vectors = 0;
  int errs    = 0;

`ifdef AXI_RD_ARB_LENCHK_EN
  localparam logic EXP_LEN_ERR = 1'b1;
`else
  localparam logic EXP_LEN_ERR = 1'b0;
`endif

  axi_read_arbiter #(.NREQ(4), .AW(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_araddr    (req_araddr),
    .req_arlen     (req_arlen),
    .req_arsize    (req_arsize),
    .req_arburst   (req_arburst),
    .req_arvalid   (req_arvalid),
    .req_arready   (req_arready),
    .req_rdata     (req_rdata),
    .req_rlast     (req_rlast),
    .req_rvalid    (req_rvalid),
    .req_rready    (req_rready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .grant         (grant),
    .busy          (busy),
    .len_err       (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] addr, input logic [7:0] len);
    req_araddr[i*32 +: 32] = addr;
    req_arlen[i*8 +: 8]    = len;
    req_arsize[i*3 +: 3]   = 3'd3;
    req_arburst[i*2 +: 2]  = 2'b01;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    req_arvalid   = '0;
    req_rready    = '0;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    m_axi_rdata   = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Drives one complete burst starting from IDLE with arvalid already set.
  // Slave is always ready; rlast is placed on beat index rlast_at. Returns
  // observations for the calling scenario to judge.
  task automatic do_burst(input int exp_g, input int rlast_at, input bit drop,
                          output int g, output logic [31:0] addr,
                          output logic [7:0] len, output logic arv,
                          output logic [3:0] arrdy, output int good,
                          output int ar_in_data);
    logic [63:0] d;
    m_axi_arready = 1'b1;
    tick();                       // now in ADDR
    g     = int'(grant);
    addr  = m_axi_araddr;
    len   = m_axi_arlen;
    arv   = m_axi_arvalid;
    arrdy = req_arready;
    tick();                       // now in DATA
    m_axi_arready = 1'b0;
    if (drop) req_arvalid[exp_g] = 1'b0;
    good       = 0;
    ar_in_data = 0;
    for (int k = 0; k <= rlast_at; k++) begin
      d            = {32'hCAFE0000 | 32'(k), addr};
      m_axi_rdata  = d;
      m_axi_rvalid = 1'b1;
      m_axi_rlast  = (k == rlast_at);
      req_rready   = 4'b0001 << exp_g;
      #1;
      if (req_rvalid === (4'b0001 << exp_g) && m_axi_rready === 1'b1 &&
          req_rdata === d &&
          req_rlast === ((k == rlast_at) ? (4'b0001 << exp_g) : 4'b0000))
        good++;
      if (m_axi_arvalid) ar_in_data++;
      tick();
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    req_rready   = '0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (m_axi_arvalid !== 1'b0) begin errs++; $display("FAIL reset_arvalid got %b want 0", m_axi_arvalid); end
    vectors++; if (m_axi_araddr !== 32'h0 || m_axi_arlen !== 8'h0 || m_axi_arsize !== 3'h0 || m_axi_arburst !== 2'h0) begin
      errs++; $display("FAIL reset_ar_fields got %h/%h/%h/%h want 0", m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst); end
    vectors++; if (m_axi_rready !== 1'b0) begin errs++; $display("FAIL reset_rready got %b want 0", m_axi_rready); end
    vectors++; if (req_arready !== 4'b0 || req_rvalid !== 4'b0 || req_rlast !== 4'b0) begin
      errs++; $display("FAIL reset_req_outs got %b/%b/%b want 0", req_arready, req_rvalid, req_rlast); end
    vectors++; if (grant !== 2'd0 || len_err !== 1'b0) begin
      errs++; $display("FAIL reset_grant_lenerr got %0d/%b want 0/0", grant, len_err); end
  endtask

  task automatic test_single();
    int g, good, aid;
    logic [31:0] addr;
    logic [7:0] len;
    logic arv;
    logic [3:0] arrdy;
    set_req(0, 32'h1000, 8'd3);
    req_arvalid = 4'b0001;
    #1;
    vectors++; if (m_axi_arvalid !== 1'b0) begin errs++; $display("FAIL single_arvalid_n got %b want 0", m_axi_arvalid); end
    do_burst(0, 3, 1'b1, g, addr, len, arv, arrdy, good, aid);
    vectors++; if (arv !== 1'b1) begin errs++; $display("FAIL single_arvalid_n1 got %b want 1", arv); end
    vectors++; if (g !== 0) begin errs++; $display("FAIL single_grant got %0d want 0", g); end
    vectors++; if (addr !== 32'h1000) begin errs++; $display("FAIL single_addr got %h want 00001000", addr); end
    vectors++; if (len !== 8'd3) begin errs++; $display("FAIL single_len got %0d want 3", len); end
    vectors++; if (arrdy !== 4'b0001) begin errs++; $display("FAIL single_arready got %b want 0001", arrdy); end
    vectors++; if (good !== 4) begin errs++; $display("FAIL single_beats got %0d want 4", good); end
    vectors++; if (busy !== 1'b0 || req_rvalid !== 4'b0 || m_axi_rready !== 1'b0) begin
      errs++; $display("FAIL single_idle got busy=%b rvalid=%b rready=%b want 0", busy, req_rvalid, m_axi_rready); end
    vectors++; if (len_err !== 1'b0) begin errs++; $display("FAIL single_len_err got %b want 0", len_err); end
  endtask

  task automatic test_round_robin();
    int g, good, aid, exp;
    logic [31:0] addr;
    logic [7:0] len;
    logic arv;
    logic [3:0] arrdy;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'h1000 * (i + 1), 8'd1);
    req_arvalid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      exp = j % 4;
      do_burst(exp, 1, 1'b0, g, addr, len, arv, arrdy, good, aid);
      vectors++; if (g !== exp) begin errs++; $display("FAIL rr_grant%0d got %0d want %0d", j, g, exp); end
      vectors++; if (addr !== 32'h1000 * (exp + 1)) begin errs++; $display("FAIL rr_addr%0d got %h want %h", j, addr, 32'h1000 * (exp + 1)); end
      vectors++; if (good !== 2 || aid !== 0) begin errs++; $display("FAIL rr_burst%0d got beats=%0d ar_in_data=%0d want 2/0", j, good, aid); end
      vectors++; if (busy !== 1'b0 || m_axi_arvalid !== 1'b0) begin
        errs++; $display("FAIL rr_gap%0d got busy=%b arvalid=%b want 0/0", j, busy, m_axi_arvalid); end
    end
    req_arvalid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    int beats, ok, cyc;
    bit stall;
    logic [63:0] d;
    do_reset();
    set_req(2, 32'h3000, 8'd3);
    req_arvalid   = 4'b0100;
    m_axi_arready = 1'b1;
    tick();
    tick();
    m_axi_arready = 1'b0;
    req_arvalid   = 4'b0000;
    beats = 0;
    ok    = 0;
    cyc   = 0;
    while (beats < 4 && cyc < 12) begin
      stall        = (cyc >= 1 && cyc <= 3);
      req_rready   = stall ? 4'b1011 : 4'b0100;
      d            = 64'hB000 + 64'(beats);
      m_axi_rdata  = d;
      m_axi_rvalid = 1'b1;
      m_axi_rlast  = (beats == 3);
      #1;
      if (stall) begin
        vectors++; if (m_axi_rready !== 1'b0) begin errs++; $display("FAIL bp_rready_c%0d got %b want 0", cyc, m_axi_rready); end
        vectors++; if (req_rvalid !== 4'b0100) begin errs++; $display("FAIL bp_rvalid_c%0d got %b want 0100", cyc, req_rvalid); end
      end
      if (m_axi_rready === 1'b1) begin
        if (req_rdata === d && req_rvalid === 4'b0100) ok++;
        beats++;
      end
      tick();
      cyc++;
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    req_rready   = '0;
    #1;
    vectors++; if (beats !== 4 || ok !== 4) begin errs++; $display("FAIL bp_beats got %0d/%0d want 4/4", beats, ok); end
    vectors++; if (cyc !== 7) begin errs++; $display("FAIL bp_cycles got %0d want 7", cyc); end
    vectors++; if (busy !== 1'b0) begin errs++; $display("FAIL bp_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int g, good, aid;
    logic [31:0] addr;
    logic [7:0] len;
    logic arv;
    logic [3:0] arrdy;
    do_reset();
    set_req(0, 32'h1000, 8'd3);
    set_req(1, 32'h2000, 8'd1);
    req_arvalid = 4'b0010;
    do_burst(1, 1, 1'b1, g, addr, len, arv, arrdy, good, aid);
    vectors++; if (g !== 1) begin errs++; $display("FAIL rm_first_grant got %0d want 1", g); end
    set_req(3, 32'h4000, 8'd3);
    req_arvalid   = 4'b1000;
    m_axi_arready = 1'b1;
    tick();
    tick();
    m_axi_arready = 1'b0;
    req_arvalid   = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rlast  = 1'b0;
      req_rready   = 4'b1000;
      tick();
    end
    m_axi_rvalid = 1'b0;
    req_rready   = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0) begin
      errs++; $display("FAIL rm_ctrl got busy=%b arvalid=%b rready=%b want 0", busy, m_axi_arvalid, m_axi_rready); end
    vectors++; if (m_axi_araddr !== 32'h0 || m_axi_arlen !== 8'h0 || grant !== 2'd0) begin
      errs++; $display("FAIL rm_fields got addr=%h len=%h grant=%0d want 0", m_axi_araddr, m_axi_arlen, grant); end
    vectors++; if (len_err !== 1'b0 || req_rvalid !== 4'b0) begin
      errs++; $display("FAIL rm_outs got len_err=%b rvalid=%b want 0", len_err, req_rvalid); end
    req_arvalid = 4'b1111;
    do_burst(0, 3, 1'b0, g, addr, len, arv, arrdy, good, aid);
    req_arvalid = 4'b0000;
    vectors++; if (g !== 0) begin errs++; $display("FAIL rm_ptr_grant got %0d want 0", g); end
    tick();
  endtask

  task automatic test_arlen0();
    int g, good, aid;
    logic [31:0] addr;
    logic [7:0] len;
    logic arv;
    logic [3:0] arrdy;
    do_reset();
    set_req(2, 32'h5000, 8'd0);
    req_arvalid = 4'b0100;
    do_burst(2, 0, 1'b1, g, addr, len, arv, arrdy, good, aid);
    vectors++; if (g !== 2 || len !== 8'd0) begin errs++; $display("FAIL a0_grant_len got %0d/%0d want 2/0", g, len); end
    vectors++; if (good !== 1) begin errs++; $display("FAIL a0_beats got %0d want 1", good); end
    vectors++; if (busy !== 1'b0 || len_err !== 1'b0) begin
      errs++; $display("FAIL a0_end got busy=%b len_err=%b want 0/0", busy, len_err); end
  endtask

  task automatic test_len_err();
    int g, good, aid;
    logic [31:0] addr;
    logic [7:0] len;
    logic arv;
    logic [3:0] arrdy;
    do_reset();
    set_req(1, 32'h6000, 8'd3);
    req_arvalid = 4'b0010;
    do_burst(1, 1, 1'b1, g, addr, len, arv, arrdy, good, aid);
    vectors++; if (len !== 8'd3 || good !== 2) begin errs++; $display("FAIL le_burst got len=%0d beats=%0d want 3/2", len, good); end
    vectors++; if (busy !== 1'b0) begin errs++; $display("FAIL le_idle got busy=%b want 0", busy); end
    vectors++; if (len_err !== EXP_LEN_ERR) begin errs++; $display("FAIL le_flag got %b want %b", len_err, EXP_LEN_ERR); end
    tick();
    tick();
    vectors++; if (len_err !== EXP_LEN_ERR) begin errs++; $display("FAIL le_sticky got %b want %b", len_err, EXP_LEN_ERR); end
  endtask

  initial begin
    rst           = 1'b1;
    req_araddr    = '0;
    req_arlen     = '0;
    req_arsize    = '0;
    req_arburst   = '0;
    req_arvalid   = '0;
    req_rready    = '0;
    m_axi_arready = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rlast   = 1'b0;
    m_axi_rvalid  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_arlen0();
    test_len_err();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares one AXI read master port (AR + R channels, 64-bit data) among `NREQ` requesters. It sits between the requesting engines and the read-bridge master, in front of the AXI read channel pair. It grants one burst at a time by round-robin and holds the grant until the last beat of that burst is accepted. It returns R beats only to the granted requester.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `AW`, 32, address width

Ports (clock, reset first; "Already decided": one clock `clk`; reset `rst` is synchronous, active-high):
- `clk` in 1: single clock; all state changes on its rising edge
- `rst` in 1: synchronous, active-high reset
- `req_araddr` in NREQ*AW: per-requester address; slice i = `[i*AW +: AW]`
- `req_arlen` in NREQ*8: per-requester burst length
- `req_arsize` in NREQ*3: per-requester burst size
- `req_arburst` in NREQ*2: per-requester burst type
- `req_arvalid` in NREQ: per-requester address request
- `req_arready` out NREQ: address accepted; one-hot or zero
- `req_rdata` out 64: read data, broadcast to all requesters
- `req_rlast` out NREQ: last beat, granted requester only
- `req_rvalid` out NREQ: beat valid, granted requester only
- `req_rready` in NREQ: per-requester data ready
- `m_axi_araddr` out AW; `m_axi_arlen` out 8; `m_axi_arsize` out 3; `m_axi_arburst` out 2: registered AR fields
- `m_axi_arvalid` out 1; `m_axi_arready` in 1
- `m_axi_rdata` in 64; `m_axi_rlast` in 1; `m_axi_rvalid` in 1; `m_axi_rready` out 1
- `grant` out log2(NREQ): index of the current owner; valid outside IDLE
- `busy` out 1: state is not IDLE
- `len_err` out 1: sticky protocol error (see Configuration)

## Operation
- FSM states: IDLE, ADDR, DATA.
- **IDLE:**
  - If any `req_arvalid` is set, pick the winner by round-robin: search starts at `ptr`, wraps modulo NREQ, and takes the first set bit.
  - Latch `grant`, plus the winner's araddr, arlen, arsize and arburst, into the `m_axi_ar*` registers.
  - Go to ADDR.
- **ADDR:**
  - `m_axi_arvalid`=1; fields are held stable.
  - On `m_axi_arready`=1:
    - `req_arready[grant]`=1 combinationally, in the same cycle.
    - `arvalid` drops next cycle.
    - Load the beat counter with `arlen`.
    - Go to DATA.
- **DATA:**
  - `m_axi_rready = req_rready[grant]`.
  - `req_rvalid[grant] = m_axi_rvalid`; `req_rlast[grant] = m_axi_rlast`. All other bits are 0.
  - `req_rdata = m_axi_rdata`, always.
  - Each beat handshake decrements the counter.
  - A handshake with `m_axi_rlast`=1 sets `ptr = grant+1` (mod NREQ) and goes to IDLE.
- Requesters must hold `req_arvalid` and the AR fields stable until `req_arready`.
- A requester that drops `req_arvalid` after winning is still served. The latched copy is issued.
- Outside DATA: `m_axi_rready`=0 and all `req_rvalid`=0.
- A `req_rready` bit from a non-granted requester has no effect.

## Timing
- Reset values:
  - state IDLE, `ptr`=0, `grant`=0
  - `m_axi_arvalid`=0, all `m_axi_ar*` fields 0
  - `m_axi_rready`=0, `busy`=0, `len_err`=0
  - `req_arready`, `req_rvalid`, `req_rlast` all 0
- Latency: `req_arvalid` seen in IDLE at cycle N gives `m_axi_arvalid`=1 at N+1.
- R path is combinational pass-through, 0 cycles.
- After an rlast handshake there is one mandatory IDLE cycle. The next grant is at the earliest 2 cycles after rlast.
- Simultaneous requests are resolved purely by `ptr`. A requester just served has lowest priority next.
- An `arlen`=0 burst is a single beat; the rlast on that beat ends DATA.
- `rst` mid-burst returns to IDLE next edge and clears everything. The downstream slave is reset by the same domain.

## Configuration
- Macro `AXI_RD_ARB_LENCHK_EN`.
- **Defined:** beat-count checker is built.
  - `len_err` is set, and held until `rst`, when `m_axi_rlast`=1 arrives on a handshake with counter ≠ 0.
  - `len_err` is also set when a handshake with counter = 0 carries `m_axi_rlast`=0. The counter saturates at 0.
  - FSM termination still follows `rlast`.
- **Undefined:** counter logic is omitted, `len_err` is tied to 0, and termination depends on `rlast` only.

## Test plan
- Single request: `req_arvalid`=4'b0001, addr 0x1000, arlen 3, slave always ready.
  - Expect: `m_axi_arvalid` one cycle later with addr 0x1000 and arlen 3.
  - Expect: 4 beats routed to requester 0 only, then IDLE. `len_err`=0.
- All four requesting continuously from reset.
  - Expect: grants in order 0,1,2,3,0.
  - Expect: each burst completes before the next AR is issued.
- Backpressure: granted requester holds `req_rready`=0 for 3 cycles mid-burst.
  - Expect: `m_axi_rready`=0 for those cycles and no beat lost.
  - Expect: a non-granted requester's `req_rready`=1 is ignored.
- Reset in DATA after 2 of 4 beats.
  - Expect: next cycle state IDLE, all outputs at reset values, `ptr`=0.
- With `AXI_RD_ARB_LENCHK_EN` defined: arlen 3, slave asserts rlast on beat 2.
  - Expect: `len_err`=1 sticky and FSM back in IDLE.
  - Expect: the same stimulus with the macro undefined gives `len_err`=0.
